// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// state encoding, exception codes and parameter defaults.
package multdiv_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [31:0] EXC_MUL = 32'd4;
   localparam logic [31:0] EXC_DIV = 32'd5;

   localparam int DEF_RSTATUS_REG = 30;
   localparam int DEF_TIMEOUT     = 40;

   typedef struct packed {
      logic        is_div;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
   } md_op_t;

   function automatic logic [31:0] exc_code(input logic is_div);
      return is_div ? EXC_DIV : EXC_MUL;
   endfunction

endpackage

// File: rtl/multdiv_ctrl_timeout_counter.sv
// 6-bit cycle counter with synchronous clear, count enable and a
// terminal-count flag; saturates rather than wrapping.
module md_timeout_counter #(
   parameter logic [5:0] TC_VALUE = 6'd39
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [5:0] count_r;

   // count register: clear wins over enable, hold at all-ones
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= 6'd0;
      end else if (clear) begin
         count_r <= 6'd0;
      end else if (enable && (count_r != 6'h3F)) begin
         count_r <= count_r + 6'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // terminal-count decode
   always_comb begin
      tc = (count_r == TC_VALUE);
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage controller that hands one mul/div at a time to an external
// multiplier/divider, stalls the pipe while it runs and emits a writeback.
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int RSTATUS_REG = DEF_RSTATUS_REG
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   input  logic        op_is_div,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  op_rd,
   input  logic        flush,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_exception
);

   // The flag fires during the BUSY cycle in which the count reaches TIMEOUT.
   localparam logic [5:0] TC_VALUE    = 6'(TIMEOUT - 1);
   localparam logic [4:0] RSTATUS_IDX = 5'(RSTATUS_REG);

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   md_op_t      op_r;
   logic [31:0] res_r;
   logic        exc_r;

   logic        is_idle_s;
   logic        is_start_s;
   logic        is_busy_s;
   logic        is_done_s;
   logic        accept_s;
   logic        rdy_take_s;
   logic        tout_s;
   logic        cnt_tc_s;
   logic        wb_valid_s;

   // state decode and qualified events
   always_comb begin
      is_idle_s  = (state_r == ST_IDLE);
      is_start_s = (state_r == ST_START);
      is_busy_s  = (state_r == ST_BUSY);
      is_done_s  = (state_r == ST_DONE);
      accept_s   = is_idle_s & op_valid & ~flush & ~reset;
      rdy_take_s = is_busy_s & ~flush & md_resultRDY;
      tout_s     = is_busy_s & ~flush & ~md_resultRDY & cnt_tc_s;
   end

   md_timeout_counter #(
      .TC_VALUE (TC_VALUE)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .clear  (is_start_s),
      .enable (is_busy_s),
      .tc     (cnt_tc_s)
   );

   // next-state logic; flush returns to IDLE from anywhere
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: state_nxt_s = ST_BUSY;
         ST_BUSY: begin
            if (md_resultRDY || cnt_tc_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
      if (flush) begin
         state_nxt_s = ST_IDLE;
      end else begin
         state_nxt_s = state_nxt_s;
      end
   end

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // operand latch and result/exception capture
   always_ff @(posedge clock) begin
      if (reset) begin
         op_r  <= '0;
         res_r <= 32'd0;
         exc_r <= 1'b0;
      end else if (accept_s) begin
         op_r  <= '{is_div: op_is_div, rd: op_rd, a: op_a, b: op_b};
         res_r <= 32'd0;
         exc_r <= 1'b0;
      end else if (rdy_take_s) begin
         res_r <= md_result;
         exc_r <= md_exception;
      end else if (tout_s) begin
         exc_r <= 1'b1;
      end else begin
         op_r  <= op_r;
         res_r <= res_r;
         exc_r <= exc_r;
      end
   end

   // outputs decoded from registered state; flush silences everything at once
   always_comb begin
      stall        = accept_s | ((is_start_s | is_busy_s) & ~flush);
      md_ctrl_MULT = is_start_s & ~flush & ~op_r.is_div;
      md_ctrl_DIV  = is_start_s & ~flush & op_r.is_div;
      md_operandA  = op_r.a;
      md_operandB  = op_r.b;
      wb_valid_s   = is_done_s & ~flush;
      wb_valid     = wb_valid_s;
      if (wb_valid_s) begin
         wb_exception = exc_r;
         wb_rd        = exc_r ? RSTATUS_IDX : op_r.rd;
         wb_data      = exc_r ? exc_code(op_r.is_div) : res_r;
      end else begin
         wb_exception = 1'b0;
         wb_rd        = 5'd0;
         wb_data      = 32'd0;
      end
   end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: the bench plays the mul/div unit and
// predicts each writeback from operand arithmetic and the RDY/timeout rules.
module tb_multdiv_ctrl;

   localparam int TMO = 40;
   localparam int RS  = 30;

   logic        clock = 1'b0;
   logic        reset, op_valid, op_is_div, flush;
   logic [31:0] op_a, op_b, md_result;
   logic [4:0]  op_rd;
   logic        md_exception, md_resultRDY;
   logic        md_ctrl_MULT, md_ctrl_DIV, stall, wb_valid, wb_exception;
   logic [31:0] md_operandA, md_operandB, wb_data;
   logic [4:0]  wb_rd;

   int total = 0;
   int bad   = 0;

   multdiv_ctrl #(.TIMEOUT(TMO), .RSTATUS_REG(RS)) dut (
      .clock(clock), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
      .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .flush(flush),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_exception(wb_exception)
   );

   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic s, input logic m, input logic d,
                          input logic v, input logic [4:0] r, input logic [31:0] dat,
                          input logic e);
      chk({tag, ".stall"}, 32'(stall), 32'(s));
      chk({tag, ".mult"}, 32'(md_ctrl_MULT), 32'(m));
      chk({tag, ".div"}, 32'(md_ctrl_DIV), 32'(d));
      chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
      chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(r));
      chk({tag, ".wb_data"}, wb_data, dat);
      chk({tag, ".wb_exc"}, 32'(wb_exception), 32'(e));
   endtask

   task automatic chk_quiet(input string tag);
      chk_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   task automatic idle(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         op_valid = 1'b0; flush = 1'b0; reset = 1'b0;
         md_resultRDY = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         md_result = $urandom; md_exception = 1'($urandom_range(0, 1));
         op_a = $urandom; op_b = $urandom;
         #1;
         chk_quiet("idle");
      end
   endtask

   // rdy_at: BUSY cycle (1-based) carrying RDY, 0 = never.
   // abort_kind 0 = flush, 1 = reset, applied on BUSY cycle abort_at (0 = none).
   task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int rdy_at, input int abort_at,
                         input int abort_kind, input bit early);
      logic [31:0] res, edata;
      logic [4:0]  erd;
      bit          uexc, tout, eexc;
      int          nb, stalls;
      res    = is_div ? ((b == 32'd0) ? $urandom : a / b) : a * b;
      uexc   = is_div && (b == 32'd0);
      tout   = !(rdy_at >= 1 && rdy_at <= TMO);
      nb     = tout ? TMO : rdy_at;
      eexc   = tout || uexc;
      erd    = eexc ? 5'(RS) : rd;
      edata  = eexc ? (is_div ? 32'd5 : 32'd4) : res;
      stalls = 0;

      @(negedge clock);
      op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b; op_rd = rd;
      flush = 1'b0; reset = 1'b0; md_resultRDY = 1'b0;
      #1;
      chk_out("accept", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      stalls += int'(stall);

      @(negedge clock);
      op_a = $urandom; op_b = $urandom; op_rd = 5'($urandom); op_is_div = 1'($urandom);
      md_resultRDY = early; md_exception = early; md_result = $urandom;
      #1;
      chk_out("start", 1'b1, !is_div, is_div, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("start.opA", md_operandA, a);
      chk("start.opB", md_operandB, b);
      stalls += int'(stall);

      for (int i = 1; i <= nb; i++) begin
         @(negedge clock);
         md_resultRDY = (i == rdy_at);
         md_result    = (i == rdy_at) ? res : $urandom;
         md_exception = (i == rdy_at) ? uexc : 1'($urandom);
         flush        = (abort_kind == 0) && (i == abort_at);
         reset        = (abort_kind == 1) && (i == abort_at);
         #1;
         if (flush) begin
            chk_quiet("flush");
            for (int k = 1; k <= 4; k++) begin
               @(negedge clock);
               flush = 1'b0; op_valid = 1'b0;
               md_resultRDY = (k == 3); md_result = res; md_exception = 1'b0;
               #1;
               chk_quiet("postflush");
            end
            return;
         end
         if (reset) begin
            @(negedge clock);
            reset = 1'b0; op_valid = 1'b0; md_resultRDY = 1'b0;
            #1;
            chk_quiet("postreset");
            chk("postreset.opA", md_operandA, 32'd0);
            chk("postreset.opB", md_operandB, 32'd0);
            idle(3, 1'b1);
            return;
         end
         chk_out("busy", 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
         stalls += int'(stall);
      end

      @(negedge clock);
      md_resultRDY = 1'b0; md_exception = 1'b0; md_result = $urandom;
      #1;
      chk_out("done", 1'b0, 1'b0, 1'b0, 1'b1, erd, edata, eexc);
      chk("done.opA", md_operandA, a);
      chk("done.opB", md_operandB, b);
      chk("stall_cycles", 32'(stalls), 32'(nb + 2));
   endtask

   initial begin
      int rdy_at, abort_at, abort_kind, nbl, r;
      logic [31:0] b;
      reset = 1'b1; op_valid = 1'b1; op_is_div = 1'b0; flush = 1'b0;
      op_a = 32'd1; op_b = 32'd2; op_rd = 5'd3;
      md_result = 32'd0; md_exception = 1'b0; md_resultRDY = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      chk("reset.stall_override", 32'(stall), 32'd0);
      @(negedge clock);
      reset = 1'b0; op_valid = 1'b0;
      #1;
      chk_quiet("reset");
      chk("reset.opA", md_operandA, 32'd0);
      chk("reset.opB", md_operandB, 32'd0);

      run_op(1'b0, 32'd7, 32'd6, 5'd5, 17, 0, 0, 1'b0);
      idle(1, 1'b0);
      run_op(1'b1, 32'd100, 32'd0, 5'd9, 4, 0, 0, 1'b0);
      idle(1, 1'b0);
      run_op(1'b0, 32'd3, 32'd3, 5'd2, 0, 0, 0, 1'b0);
      idle(2, 1'b1);
      run_op(1'b1, 32'd50, 32'd7, 5'd3, TMO, 0, 0, 1'b0);
      idle(1, 1'b0);
      run_op(1'b0, 32'd11, 32'd12, 5'd6, TMO + 1, 0, 0, 1'b0);
      run_op(1'b0, 32'd9, 32'd9, 5'd4, 8, 5, 0, 1'b0);
      run_op(1'b0, 32'd13, 32'd2, 5'd8, 2, 0, 0, 1'b1);
      idle(1, 1'b0);
      run_op(1'b1, 32'd81, 32'd9, 5'd12, 10, 3, 1, 1'b0);
      run_op(1'b0, 32'd21, 32'd2, 5'd1, 3, 0, 0, 1'b0);
      run_op(1'b0, 32'd5, 32'd5, 5'd2, 1, 0, 0, 1'b0);
      idle(1, 1'b0);

      @(negedge clock);
      op_valid = 1'b1; flush = 1'b1;
      #1;
      chk_quiet("idle_flush");
      @(negedge clock);
      op_valid = 1'b0; flush = 1'b0;
      #1;
      chk_quiet("idle_flush_next");

      for (int n = 0; n < 14; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) rdy_at = 0;
         else if (r == 1) rdy_at = $urandom_range(TMO - 2, TMO + 5);
         else rdy_at = $urandom_range(1, 20);
         nbl = (rdy_at >= 1 && rdy_at <= TMO) ? rdy_at : TMO;
         abort_kind = $urandom_range(0, 1);
         abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nbl) : 0;
         b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         run_op(1'($urandom), $urandom, b, 5'($urandom), rdy_at, abort_at, abort_kind,
                1'($urandom));
         idle($urandom_range(0, 2), 1'b1);
      end
      idle(2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
